instr_encoder_writer: RTL
=========================

Name: instr_encoder_writer

Overview:
- Packs instruction fields (opcode, two source registers, destination register, immediate) into 32-bit instruction words.
- Writes the packed words sequentially into instruction memory over a simple write port.
- Its field map is the exact inverse of the pipeline's instruction decode map: opcode[31:28], reg1[27:24], reg2[23:20], dest_reg[19:16], immediate[15:0].
- Sits between the testbench/boot program loader and the instruction memory feeding the fetch stage.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width; capacity DEPTH = 2**ADDR_WIDTH words.
- START_ADDR, 0, first write address of each load session; must be < DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load session; honoured only in IDLE.
- in_valid  input  1  field tuple valid.
- in_ready  output  1  block accepts a tuple this cycle.
- opcode  input  4  opcode field.
- reg1  input  4  source register 1 field.
- reg2  input  4  source register 2 field.
- dest_reg  input  4  destination register field.
- immediate  input  16  immediate field.
- last  input  1  qualifies the final tuple of the session.
- mem_we  output  1  instruction memory write enable, one cycle per word.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_wdata  output  32  packed instruction word.
- busy  output  1  session in progress.
- done  output  1  one-cycle end-of-session pulse.
- overflow  output  1  sticky: session aborted at capacity.
- word_count  output  ADDR_WIDTH+1  words written in the current or last session.

Behaviour:
- Reset:
  - Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
  - On reset, all outputs are 0, state is IDLE, write pointer is START_ADDR.
  - Reset mid-session aborts immediately. No mem_we follows. Already-written words are not rolled back.
- States: IDLE, LOAD.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> LOAD next cycle; ptr<=START_ADDR, word_count<=0, overflow<=0.
- LOAD:
  - busy=1.
  - in_ready = (word_count < DEPTH), combinational from registered state.
  - start is ignored.
- Accept:
  - Occurs when in_valid && in_ready in cycle N.
  - Cycle N+1: mem_we=1, mem_addr=ptr, mem_wdata={opcode,reg1,reg2,dest_reg,immediate}.
  - ptr increments modulo DEPTH (wraps DEPTH-1 -> 0); word_count increments.
  - mem_we is registered, latency 1, throughput one word per cycle back-to-back.
  - Field inputs must be stable only in the accept cycle.
- last accepted in cycle N:
  - Cycle N+1: final mem_we and done=1 together; state=IDLE, busy=0.
- Full:
  - When word_count==DEPTH, in_ready=0.
  - in_valid=1 in that state -> next cycle overflow=1 (sticky until next start), done=1, state IDLE, no write.
- word_count:
  - Holds its value after done until the next start.
  - Never exceeds DEPTH.
- in_valid without ready: no effect; the tuple must be held by the source.

Optional Feature:
- Macro: INSTR_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (32 bits): XOR of every mem_wdata written in the session.
  - Cleared to 0 on accepted start and on reset.
  - Updated in the same cycle as each mem_we.
  - Final value is valid in the done cycle and held until the next start.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Single word: start; tuple op=1,r1=2,r2=3,rd=4,imm=16'hBEEF,last=1 -> next cycle mem_we=1, mem_addr=0, mem_wdata=32'h1234BEEF, done=1, word_count=1, busy=0.
- Back-to-back with gaps: 3 tuples (in_valid low one cycle between 2nd and 3rd), last on 3rd -> 3 writes at addr 0,1,2, one cycle after each accept; done with the 3rd; word_count=3.
- Wrap: ADDR_WIDTH=8, START_ADDR=254, 3 words -> mem_addr 254,255,0; no overflow.
- Capacity: ADDR_WIDTH=2, 4 words without last -> in_ready=0 after the 4th; in_valid held -> overflow=1, done=1, no 5th write; word_count=4. Next start clears overflow.
- Reset mid-session: after 2 accepts, assert rst_n low asynchronously (not clock-aligned) -> mem_we, busy, done, word_count, overflow all 0 immediately; no further writes; start after release writes from START_ADDR again.
- With INSTR_CHECKSUM_EN: words 32'h1234BEEF and 32'h00000001 -> checksum=32'h1234BEEE in the done cycle; a start during LOAD is ignored and leaves checksum unchanged.

Source files
------------

// File: rtl/instr_encoder_writer.sv
// Packs opcode/register/immediate fields into 32-bit instruction words and writes them sequentially
// into instruction memory. Define INSTR_CHECKSUM_EN to add a per-session XOR checksum output.
module instr_encoder_writer #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned START_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            opcode,
   input  logic [3:0]            reg1,
   input  logic [3:0]            reg2,
   input  logic [3:0]            dest_reg,
   input  logic [15:0]           immediate,
   input  logic                  last,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [ADDR_WIDTH:0]   word_count
`ifdef INSTR_CHECKSUM_EN
   ,
   output logic [31:0]           checksum
`endif
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] LOAD = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  we_q, we_d;
   logic                  done_q, done_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           word_c;
   logic                  ready_c;
`ifdef INSTR_CHECKSUM_EN
   logic [31:0]           cks_q, cks_d;
`endif

   // Field map is the inverse of the decode stage's map.
   assign word_c  = {opcode, reg1, reg2, dest_reg, immediate};
   assign ready_c = (state_q == LOAD) && (cnt_q < CW'(DEPTH));

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef INSTR_CHECKSUM_EN
      cks_d   = cks_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               ptr_d   = ADDR_WIDTH'(START_ADDR);
               cnt_d   = '0;
               ovf_d   = 1'b0;
`ifdef INSTR_CHECKSUM_EN
               cks_d   = '0;
`endif
            end
         end
         LOAD: begin
            if (in_valid && ready_c) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = word_c;
               ptr_d   = ptr_q + ADDR_WIDTH'(1);
               cnt_d   = cnt_q + CW'(1);
`ifdef INSTR_CHECKSUM_EN
               cks_d   = cks_q ^ word_c;
`endif
               if (last) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end else if (in_valid) begin
               // Source still pushing with memory full: abort the session.
               ovf_d   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= ADDR_WIDTH'(START_ADDR);
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef INSTR_CHECKSUM_EN
         cks_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         we_q    <= we_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef INSTR_CHECKSUM_EN
         cks_q   <= cks_d;
`endif
      end
   end

   assign in_ready   = ready_c;
   assign busy       = (state_q == LOAD);
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign done       = done_q;
   assign overflow   = ovf_q;
   assign word_count = cnt_q;
`ifdef INSTR_CHECKSUM_EN
   assign checksum   = cks_q;
`endif

endmodule
